pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Fetch-stage program-counter generator for the 5-stage MIPS pipeline. It owns the PC register and predicts the next fetch address with a direct-mapped branch target buffer (BTB). It resolves branch/j/jr outcomes reported by EX, redirects fetch and raises flush on a misprediction. It replaces the purely combinational next-PC mux with a registered, parametrised, predicting unit.

Parameters:
XLEN, 32, address/data width; must be >= 32
RESET_PC, 32'h0000_0000, PC value loaded on reset
BTB_DEPTH, 8, BTB entries; power of 2, >= 2; IDX = log2(BTB_DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold PC (hazard unit)
pc_o  out  XLEN  current fetch address
pc_plus4_o  out  XLEN  pc_o + 4
pred_taken_o  out  1  BTB hit for pc_o; travels down the pipe with the instruction
pred_target_o  out  XLEN  predicted target; valid when pred_taken_o = 1
ex_valid_i  in  1  EX holds a valid instruction
ex_pc4_i  in  XLEN  PC+4 of the EX instruction
ex_is_branch_i  in  1  conditional branch in EX
ex_taken_i  in  1  branch condition true
ex_jmp_i  in  1  j/jal in EX
ex_jr_i  in  1  jr in EX
ex_ext18_i  in  XLEN  sign-extended, <<2 branch offset
ex_target_i  in  26  jump target field
ex_rs_i  in  XLEN  $rs value for jr
ex_pred_taken_i  in  1  prediction carried with the EX instruction
ex_pred_target_i  in  XLEN  predicted target carried with the EX instruction
flush_o  out  1  kill the IF/ID instructions this cycle

Behaviour:
- Reset (async, rst_n = 0): pc_o = RESET_PC, all BTB valid bits = 0, flush_o = 0. pred_taken_o = 0 because no BTB entry is valid.
- BTB entry fields: valid, tag = pc[XLEN-1:IDX+2], target. Index = pc[IDX+1:2].
- Lookup is combinational on pc_o. pred_taken_o = valid && tag match. On a miss, pred_target_o = pc_plus4_o.
- Resolution (combinational):
  - branch_addr = ex_pc4_i + ex_ext18_i.
  - jmp_addr = {ex_pc4_i[XLEN-1:28], ex_target_i, 2'b00}.
  - actual_taken = ex_is_branch_i&&ex_taken_i || ex_jr_i || ex_jmp_i.
  - actual_target priority: branch > jr > jmp. With none of these, actual_target = ex_pc4_i.
- mispredict = ex_valid_i && (actual_taken != ex_pred_taken_i || (actual_taken && actual_target != ex_pred_target_i)).
- flush_o = mispredict. It is combinational and lasts exactly the cycles mispredict holds.
- PC update priority at clk, highest first:
  1. mispredict: pc <= actual_taken ? actual_target : ex_pc4_i.
  2. stall_i: pc holds.
  3. Otherwise: pc <= pred_taken_o ? pred_target_o : pc_plus4_o.
- Mispredict overrides stall.
- BTB update at clk, when ex_valid_i with a cti (is_branch|jmp|jr), independent of stall_i:
  - actual_taken: write valid=1, tag, target=actual_target at the index of (ex_pc4_i - 4).
  - Not-taken branch whose tag matches: clear valid.
  - Otherwise: no change.
- Same-index lookup and update in one cycle: the lookup sees the old contents (read-before-write).
- All adds wrap modulo 2^XLEN. Low two PC bits are not checked.
- Reset asserted mid-operation takes effect immediately, whatever the other inputs.

Decomposition:
- Shared package mips_pkg: XLEN default, RESET_PC, the BTB entry struct typedef, and the cti priority encoding constants.
- One sub-module: pc_btb (storage, lookup, update). The PC register and resolution logic stay in pc_next_unit.

Test Plan:
1. Reset then 4 unstalled cycles, no EX activity -> pc_o = 0x0, 0x4, 0x8, 0xC; flush_o = 0.
2. EX beq at ex_pc4 = 0x14, taken, ext18 = 0x20, pred 0 -> flush_o = 1 that cycle; next pc_o = 0x34. On the next fetch of 0x10: pred_taken_o = 1, pred_target_o = 0x34.
3. jr with ex_rs = 0x400 and jmp both asserted, ex_pc4 = 0x1000_0008, pred 0 -> pc becomes 0x400 (jr beats jmp). With jmp alone and target = 0x10 -> pc = 0x1000_0040.
4. Trained BTB entry at 0x10, then EX reports not-taken with pred 1 -> flush_o = 1, pc = ex_pc4 = 0x14, entry invalidated; the next fetch of 0x10 has pred_taken_o = 0.
5. stall_i = 1 for 3 cycles with no EX activity -> pc_o constant. Mispredict during the stall -> pc redirected next edge, flush_o = 1.
6. Correct prediction (pred_taken = 1, pred_target = actual = 0x34) -> flush_o = 0, no redirect. Assert rst_n low mid-run -> pc_o = RESET_PC immediately, all BTB entries miss.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: default widths, reset PC,
// BTB entry layout and the control-transfer (cti) priority encoding.
package mips_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int          BTB_DEPTH_DEF = 8;
  localparam int          BTB_IDX_DEF   = $clog2(BTB_DEPTH_DEF);

  // Entry layout for the default configuration; tag excludes index and byte bits.
  typedef struct packed {
    logic                              valid;
    logic [XLEN_DEF-BTB_IDX_DEF-3:0]   tag;
    logic [XLEN_DEF-1:0]               target;
  } btb_entry_t;

  // Target-selection encoding, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    CTI_NONE   = 2'd0,
    CTI_BRANCH = 2'd1,
    CTI_JR     = 2'd2,
    CTI_JMP    = 2'd3
  } cti_e;

  function automatic cti_e cti_select(input logic br_taken,
                                      input logic jr,
                                      input logic jmp);
    if (br_taken)  return CTI_BRANCH;
    else if (jr)   return CTI_JR;
    else if (jmp)  return CTI_JMP;
    else           return CTI_NONE;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// clocked train/invalidate from EX. Lookups see pre-update contents.
module pc_btb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            hit_o,
  output logic [XLEN-1:0] hit_target_o,
  input  logic            wr_en_i,
  input  logic            inv_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int IDX   = $clog2(DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  logic [IDX-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             unused_low_bits;

  assign l_idx = lookup_pc_i[IDX+1:2];
  assign l_tag = lookup_pc_i[XLEN-1:IDX+2];
  assign u_idx = upd_pc_i[IDX+1:2];
  assign u_tag = upd_pc_i[XLEN-1:IDX+2];
  assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign hit_o        = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign hit_target_o = target_q[l_idx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    if (wr_en_i) begin
      valid_d[u_idx] = 1'b1;
    end else if (inv_en_i && (tag_q[u_idx] == u_tag)) begin
      valid_d[u_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: tag/target storage is not reset; a cleared valid bit makes its contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target_i;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-stage PC register with BTB prediction; resolves EX control transfers,
// redirects fetch and flushes IF/ID on a misprediction.
module pc_next_unit
  import mips_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              BTB_DEPTH = BTB_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc4_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_taken_i,
  input  logic            ex_jmp_i,
  input  logic            ex_jr_i,
  input  logic [XLEN-1:0] ex_ext18_i,
  input  logic [25:0]     ex_target_i,
  input  logic [XLEN-1:0] ex_rs_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            flush_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;
  logic [XLEN-1:0] branch_addr, jmp_addr, actual_target;
  logic            actual_taken, mispredict, is_cti;
  cti_e            cti_sel;

  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + XLEN'(4);
  assign pred_taken_o  = btb_hit;
  assign pred_target_o = btb_hit ? btb_target : pc_plus4_o;
  assign flush_o       = mispredict;
  assign is_cti        = ex_is_branch_i || ex_jmp_i || ex_jr_i;

  always_comb begin
    branch_addr  = ex_pc4_i + ex_ext18_i;
    jmp_addr     = {ex_pc4_i[XLEN-1:28], ex_target_i, 2'b00};
    cti_sel      = cti_select(ex_is_branch_i && ex_taken_i, ex_jr_i, ex_jmp_i);
    actual_taken = (cti_sel != CTI_NONE);
    unique case (cti_sel)
      CTI_BRANCH: actual_target = branch_addr;
      CTI_JR:     actual_target = ex_rs_i;
      CTI_JMP:    actual_target = jmp_addr;
      default:    actual_target = ex_pc4_i;
    endcase
    mispredict = ex_valid_i &&
                 ((actual_taken != ex_pred_taken_i) ||
                  (actual_taken && (actual_target != ex_pred_target_i)));
  end

  // A resolved misprediction wins over the hazard stall.
  always_comb begin
    pc_d = pc_q;
    if (mispredict)    pc_d = actual_taken ? actual_target : ex_pc4_i;
    else if (!stall_i) pc_d = pred_taken_o ? pred_target_o : pc_plus4_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  pc_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_pc_i  (pc_q),
    .hit_o        (btb_hit),
    .hit_target_o (btb_target),
    .wr_en_i      (ex_valid_i && is_cti && actual_taken),
    .inv_en_i     (ex_valid_i && ex_is_branch_i && !actual_taken),
    .upd_pc_i     (ex_pc4_i - XLEN'(4)),
    .upd_target_i (actual_target)
  );

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: expectations are queued as stimulus is
// driven and popped/compared once the outputs have settled.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] pc_o, pc_plus4_o, pred_target_o;
  logic        pred_taken_o, flush_o;
  logic        ex_valid_i, ex_is_branch_i, ex_taken_i, ex_jmp_i, ex_jr_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pc4_i, ex_ext18_i, ex_rs_i, ex_pred_target_i;
  logic [25:0] ex_target_i;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        chk_pred;
    logic        ptk;
    logic [31:0] ptg;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .pc_o             (pc_o),
    .pc_plus4_o       (pc_plus4_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid_i),
    .ex_pc4_i         (ex_pc4_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_taken_i       (ex_taken_i),
    .ex_jmp_i         (ex_jmp_i),
    .ex_jr_i          (ex_jr_i),
    .ex_ext18_i       (ex_ext18_i),
    .ex_target_i      (ex_target_i),
    .ex_rs_i          (ex_rs_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .flush_o          (flush_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic fl);
    sb.push_back('{tag, pc, fl, 1'b0, 1'b0, 32'h0});
  endtask

  task automatic push_pred(input string tag, input logic [31:0] pc,
                           input logic ptk, input logic [31:0] ptg);
    sb.push_back('{tag, pc, 1'b0, 1'b1, ptk, ptg});
  endtask

  // Let combinational outputs settle, then retire every queued expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, "/pc"}, pc_o, e.pc);
      cmp({e.tag, "/flush"}, {31'b0, flush_o}, {31'b0, e.flush});
      if (e.chk_pred) begin
        cmp({e.tag, "/pred_taken"}, {31'b0, pred_taken_o}, {31'b0, e.ptk});
        cmp({e.tag, "/pred_target"}, pred_target_o, e.ptg);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ex_idle();
    ex_valid_i = 0; ex_is_branch_i = 0; ex_taken_i = 0; ex_jmp_i = 0; ex_jr_i = 0;
    ex_pc4_i = 0; ex_ext18_i = 0; ex_target_i = 0; ex_rs_i = 0;
    ex_pred_taken_i = 0; ex_pred_target_i = 0;
  endtask

  task automatic ex_branch(input logic [31:0] pc4, input logic [31:0] off, input logic tk,
                           input logic ptk, input logic [31:0] ptg);
    ex_idle();
    ex_valid_i = 1; ex_is_branch_i = 1; ex_taken_i = tk; ex_pc4_i = pc4; ex_ext18_i = off;
    ex_pred_taken_i = ptk; ex_pred_target_i = ptg;
  endtask

  task automatic ex_jump(input logic [31:0] pc4, input logic [25:0] tgt,
                         input logic jr, input logic [31:0] rs);
    ex_idle();
    ex_valid_i = 1; ex_jmp_i = 1; ex_jr_i = jr; ex_pc4_i = pc4; ex_target_i = tgt; ex_rs_i = rs;
  endtask

  initial begin
    rst_n = 0; stall_i = 0; ex_idle();
    @(negedge clk);
    push_pred("reset", 32'h0, 1'b0, 32'h4);
    drain();
    tick();
    rst_n = 1;

    // 1: free-running fetch
    push_pred("seq0", 32'h0, 1'b0, 32'h4); drain(); tick();
    push("seq4", 32'h4, 1'b0); drain(); tick();
    push("seq8", 32'h8, 1'b0); drain(); tick();
    push("seqC", 32'hC, 1'b0); drain();

    // 2: taken beq mispredicted, BTB trained for 0x10
    ex_branch(32'h14, 32'h20, 1'b1, 1'b0, 32'h0);
    push("beq_flush", 32'hC, 1'b1); drain(); tick();
    ex_idle();
    push("beq_redirect", 32'h34, 1'b0); drain();
    ex_jump(32'h8, 26'h4, 1'b0, 32'h0);
    push("j_to_10_flush", 32'h34, 1'b1); drain(); tick();
    ex_idle();
    push_pred("btb_hit_10", 32'h10, 1'b1, 32'h34); drain(); tick();
    push("follow_pred", 32'h34, 1'b0); drain();

    // 3: jr beats jmp; jmp alone keeps upper PC bits
    ex_jump(32'h1000_0008, 26'h10, 1'b1, 32'h400);
    push("jr_flush", 32'h34, 1'b1); drain(); tick();
    ex_idle();
    push("jr_wins", 32'h400, 1'b0); drain();
    ex_jump(32'h1000_0008, 26'h10, 1'b0, 32'h0);
    push("jmp_flush", 32'h400, 1'b1); drain(); tick();
    ex_idle();
    push("jmp_target", 32'h1000_0040, 1'b0); drain();

    // 4: predicted-taken branch resolves not taken -> invalidate 0x10
    ex_branch(32'h14, 32'h20, 1'b0, 1'b1, 32'h34);
    push("nt_flush", 32'h1000_0040, 1'b1); drain(); tick();
    ex_jump(32'h8, 26'h4, 1'b0, 32'h0);
    push("nt_redirect", 32'h14, 1'b1); drain(); tick();
    ex_idle();
    push_pred("btb_invalid_10", 32'h10, 1'b0, 32'h14); drain(); tick();
    push("after_inval", 32'h14, 1'b0); drain();

    // 5: stall holds PC; mispredict overrides stall
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      push($sformatf("stall_hold%0d", i), 32'h14, 1'b0); drain();
    end
    ex_branch(32'h14, 32'h20, 1'b1, 1'b0, 32'h0);
    push("stall_mispred_flush", 32'h14, 1'b1); drain(); tick();
    ex_idle();
    push("stall_mispred_redirect", 32'h34, 1'b0); drain();
    stall_i = 0;

    // 6: correct prediction; then asynchronous reset mid-run
    ex_branch(32'h14, 32'h20, 1'b1, 1'b1, 32'h34);
    push("correct_pred_noflush", 32'h34, 1'b0); drain(); tick();
    ex_idle();
    push("correct_pred_seq", 32'h38, 1'b0); drain();
    ex_jump(32'h8, 26'h4, 1'b0, 32'h0);
    tick();
    ex_idle();
    push_pred("pre_reset_hit_10", 32'h10, 1'b1, 32'h34); drain();
    #2;
    rst_n = 0;
    push_pred("async_reset", 32'h0, 1'b0, 32'h4); drain();
    @(negedge clk);
    rst_n = 1;
    ex_jump(32'h8, 26'h4, 1'b0, 32'h0);
    tick();
    ex_idle();
    push_pred("post_reset_miss_10", 32'h10, 1'b0, 32'h14); drain();

    // Wrap: branch offset -8 from 0x4 lands on 0xFFFF_FFFC
    ex_branch(32'h4, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0);
    tick();
    ex_idle();
    push("wrap_target", 32'hFFFF_FFFC, 1'b0); drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
